accel_seq_ctrl: RTL and testbench

//  Sequencer for the template accelerator. On a software start it streams N_IN words

---
 rtl/accel_seq_ctrl_if.sv | 54 +++++
 rtl/accel_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_accel_seq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_seq_ctrl_if.sv
// Handshake and buffer bus between the sequencer and the accelerator datapath.
// master: sequencer side (drives buffer addresses, write stream, read ready).
// slave : datapath/buffer side (drives buffer read data, write ready, done,
//         result stream).
interface accel_seq_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 5
);
    logic [CNT_W-1:0]  ibuf_raddr_o;
    logic [DATA_W-1:0] ibuf_rdata_i;
    logic              acc_wr_valid_o;
    logic [DATA_W-1:0] acc_wr_data_o;
    logic              acc_wr_ready_i;
    logic              acc_start_o;
    logic              acc_done_i;
    logic              acc_rd_valid_i;
    logic [DATA_W-1:0] acc_rd_data_i;
    logic              acc_rd_ready_o;
    logic              obuf_we_o;
    logic [CNT_W-1:0]  obuf_waddr_o;
    logic [DATA_W-1:0] obuf_wdata_o;

    modport master (
        output ibuf_raddr_o,
        input  ibuf_rdata_i,
        output acc_wr_valid_o,
        output acc_wr_data_o,
        input  acc_wr_ready_i,
        output acc_start_o,
        input  acc_done_i,
        input  acc_rd_valid_i,
        input  acc_rd_data_i,
        output acc_rd_ready_o,
        output obuf_we_o,
        output obuf_waddr_o,
        output obuf_wdata_o
    );

    modport slave (
        input  ibuf_raddr_o,
        output ibuf_rdata_i,
        input  acc_wr_valid_o,
        input  acc_wr_data_o,
        output acc_wr_ready_i,
        input  acc_start_o,
        output acc_done_i,
        output acc_rd_valid_i,
        output acc_rd_data_i,
        input  acc_rd_ready_o,
        input  obuf_we_o,
        input  obuf_waddr_o,
        input  obuf_wdata_o
    );
endinterface

// File: rtl/accel_seq_ctrl.sv
// Sequencer for the template accelerator: streams N_IN input-buffer words into
// the accelerator, pulses its start, waits for done (bounded by TIMEOUT) and
// drains N_OUT result words into the output buffer.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   cfg_start_i/cfg_clear_i start request / abort-acknowledge from reg file
//   cfg_n_in_i/cfg_n_out_i  word counts latched on start
//   status_o/error_o        current state / error of last run
//   busy_o, irq_o           run in progress / 1-cycle pulse on entering DONE
//   bus (master)            buffer ports and accelerator handshakes
package cfg_types_pkg;
    typedef enum logic [3:0] {
        ST_IDLE        = 4'h0,
        ST_WRITE       = 4'h1,
        ST_START_ACCEL = 4'h2,
        ST_WAIT        = 4'h3,
        ST_READ        = 4'h4,
        ST_DONE        = 4'h5
    } acc_state_t;

    typedef enum logic [3:0] {
        ER_OKAY        = 4'h0,
        ER_INVALID_CFG = 4'h1,
        ER_OTHERS      = 4'h2
    } acc_error_t;
endpackage

module accel_seq_ctrl
    import cfg_types_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_WORDS = 16,
    parameter int unsigned CNT_W     = $clog2(MAX_WORDS + 1),
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start_i,
    input  logic             cfg_clear_i,
    input  logic [CNT_W-1:0] cfg_n_in_i,
    input  logic [CNT_W-1:0] cfg_n_out_i,
    output acc_state_t       status_o,
    output acc_error_t       error_o,
    output logic             busy_o,
    output logic             irq_o,
    accel_seq_ctrl_if.master bus
);
    localparam int unsigned TO_W = $clog2(TIMEOUT);

    acc_state_t       state_q, state_d;
    acc_error_t       err_q, err_d;
    logic [CNT_W-1:0] n_in_q, n_in_d, n_out_q, n_out_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;
    logic             irq_d, busy_d;
    logic             wr_valid_q, start_q, rd_ready_q;
    logic             rd_fire;

    // State register and registered control outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            err_q      <= ER_OKAY;
            n_in_q     <= '0;
            n_out_q    <= '0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            tcnt_q     <= '0;
            irq_o      <= 1'b0;
            busy_o     <= 1'b0;
            wr_valid_q <= 1'b0;
            start_q    <= 1'b0;
            rd_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            n_in_q     <= n_in_d;
            n_out_q    <= n_out_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            tcnt_q     <= tcnt_d;
            irq_o      <= irq_d;
            busy_o     <= busy_d;
            wr_valid_q <= (state_d == ST_WRITE);
            start_q    <= (state_d == ST_START_ACCEL);
            rd_ready_q <= (state_d == ST_READ);
        end
    end

    // Next-state, counters and error; clear overrides everything
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        n_in_d  = n_in_q;
        n_out_d = n_out_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        tcnt_d  = tcnt_q;
        rd_fire = (state_q == ST_READ) && bus.acc_rd_valid_i;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start_i) begin
                    n_in_d  = cfg_n_in_i;
                    n_out_d = cfg_n_out_i;
                    wcnt_d  = '0;
                    rcnt_d  = '0;
                    if ((cfg_n_in_i == '0) || (cfg_n_in_i > CNT_W'(MAX_WORDS)) ||
                        (cfg_n_out_i > CNT_W'(MAX_WORDS))) begin
                        state_d = ST_DONE;
                        err_d   = ER_INVALID_CFG;
                    end else begin
                        state_d = ST_WRITE;
                        err_d   = ER_OKAY;
                    end
                end
            end
            ST_WRITE: begin
                if (bus.acc_wr_ready_i) begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                    if (wcnt_q == n_in_q - CNT_W'(1)) begin
                        state_d = ST_START_ACCEL;
                    end
                end
            end
            ST_START_ACCEL: begin
                tcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                tcnt_d = tcnt_q + TO_W'(1);
                // done seen on the last allowed cycle still counts as success
                if (bus.acc_done_i) begin
                    state_d = (n_out_q != '0) ? ST_READ : ST_DONE;
                end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = ST_DONE;
                    err_d   = ER_OTHERS;
                end
            end
            ST_READ: begin
                if (bus.acc_rd_valid_i) begin
                    rcnt_d = rcnt_q + CNT_W'(1);
                    if (rcnt_q == n_out_q - CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cfg_clear_i) begin
            state_d = ST_IDLE;
            err_d   = ER_OKAY;
            n_in_d  = '0;
            n_out_d = '0;
            wcnt_d  = '0;
            rcnt_d  = '0;
            tcnt_d  = '0;
        end

        irq_d  = (state_d == ST_DONE) && (state_q != ST_DONE);
        busy_d = (state_d == ST_WRITE) || (state_d == ST_START_ACCEL) ||
                 (state_d == ST_WAIT)  || (state_d == ST_READ);
    end

    assign status_o = state_q;
    assign error_o  = err_q;

    // Buffer-facing paths are same-cycle by design of the buffers
    assign bus.ibuf_raddr_o   = wcnt_q;
    assign bus.acc_wr_valid_o = wr_valid_q;
    assign bus.acc_wr_data_o  = wr_valid_q ? bus.ibuf_rdata_i : '0;
    assign bus.acc_start_o    = start_q;
    assign bus.acc_rd_ready_o = rd_ready_q;
    assign bus.obuf_we_o      = rd_fire;
    assign bus.obuf_waddr_o   = rd_fire ? rcnt_q : '0;
    assign bus.obuf_wdata_o   = rd_fire ? bus.acc_rd_data_i : '0;
endmodule

// File: tb/tb_accel_seq_ctrl.sv
module tb_accel_seq_ctrl;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_WORDS = 16;
    localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1);
    localparam int unsigned TIMEOUT   = 16;
    localparam int unsigned AW        = CNT_W + DATA_W;
    localparam int unsigned DEPTH     = 2 ** CNT_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             cfg_start, cfg_clear;
    logic [CNT_W-1:0] cfg_n_in, cfg_n_out;
    logic [3:0]       status, error;
    logic             busy, irq;

    accel_seq_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    accel_seq_ctrl #(
        .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start_i(cfg_start), .cfg_clear_i(cfg_clear),
        .cfg_n_in_i(cfg_n_in), .cfg_n_out_i(cfg_n_out),
        .status_o(status), .error_o(error), .busy_o(busy), .irq_o(irq),
        .bus(bus)
    );

    // Input buffer (combinational read) and accelerator result words
    logic [DATA_W-1:0] mem    [DEPTH];
    logic [DATA_W-1:0] rwords [DEPTH];
    assign bus.ibuf_rdata_i = mem[bus.ibuf_raddr_o];

    int n_cmp = 0;
    int n_mis = 0;

    logic [AW-1:0] q_wr[$];
    logic [AW-1:0] q_ob[$];
    logic [7:0]    q_end[$];

    int cyc        = 0;
    int start_cyc  = -1;
    int done_d     = 0;
    bit done_lvl   = 1'b0;
    int rmode      = 0;
    int vmode      = 0;
    int ridx       = 0;
    int wr_acc     = 0;
    int hold_after = -1;
    int nstart     = 0;
    int nirq       = 0;
    int irq_cyc    = 0;

    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_word  = '0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Accelerator / handshake partner
    initial begin
        bus.acc_wr_ready_i = 1'b0;
        bus.acc_done_i     = 1'b0;
        bus.acc_rd_valid_i = 1'b0;
        bus.acc_rd_data_i  = '0;
        forever begin
            logic rdy;
            @(posedge clk);
            #1;
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = cyc[0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (hold_after >= 0 && wr_acc >= hold_after) rdy = 1'b0;
            bus.acc_wr_ready_i = rdy;
            if (start_cyc >= 0 && done_d > 0)
                bus.acc_done_i = done_lvl ? (cyc >= start_cyc + done_d) : (cyc == start_cyc + done_d);
            else
                bus.acc_done_i = 1'b0;
            bus.acc_rd_valid_i = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.acc_rd_data_i  = rwords[ridx % DEPTH];
        end
    end

    // Monitor: pops scoreboard entries whenever the DUT presents a transfer
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && bus.acc_wr_valid_o)
                check("wr_hold_stable", 64'({bus.ibuf_raddr_o, bus.acc_wr_data_o}), 64'(prev_word));
            prev_stall = bus.acc_wr_valid_o && !bus.acc_wr_ready_i;
            prev_word  = {bus.ibuf_raddr_o, bus.acc_wr_data_o};

            if (bus.acc_wr_valid_o && bus.acc_wr_ready_i) begin
                wr_acc++;
                check("wr_expected", 64'(q_wr.size() != 0), 64'(1));
                if (q_wr.size() != 0)
                    check("wr_word", 64'({bus.ibuf_raddr_o, bus.acc_wr_data_o}), 64'(q_wr.pop_front()));
            end
            if (bus.acc_start_o) begin
                nstart++;
                start_cyc = cyc;
            end
            if (bus.acc_rd_valid_i && bus.acc_rd_ready_o) ridx++;
            if (bus.obuf_we_o) begin
                check("ob_expected", 64'(q_ob.size() != 0), 64'(1));
                if (q_ob.size() != 0)
                    check("ob_word", 64'({bus.obuf_waddr_o, bus.obuf_wdata_o}), 64'(q_ob.pop_front()));
            end
            if (irq) begin
                nirq++;
                irq_cyc = cyc;
                check("end_expected", 64'(q_end.size() != 0), 64'(1));
                if (q_end.size() != 0)
                    check("end_status_error", 64'({status, error}), 64'(q_end.pop_front()));
            end
        end
    end

    task automatic fresh_data();
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i]    = $urandom;
            rwords[i] = $urandom;
        end
    endtask

    task automatic issue_start(input int n_in, input int n_out, output int t0);
        @(posedge clk);
        #1;
        cfg_n_in  = CNT_W'(n_in);
        cfg_n_out = CNT_W'(n_out);
        cfg_start = 1'b1;
        t0        = cyc;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic do_clear();
        cfg_clear = 1'b1;
        @(posedge clk);
        #1;
        cfg_clear = 1'b0;
        check("clr_status", 64'(status), 64'(0));
        check("clr_error", 64'(error), 64'(0));
        check("clr_busy", 64'(busy), 64'(0));
    endtask

    // One full run against the reference expectations
    task automatic run(input int n_in, input int n_out, input int d, input bit lvl,
                       input int rm, input int vm);
        bit valid_cfg, done_ok;
        int exp_err, exp_lat, t0;
        fresh_data();
        start_cyc = -1; done_d = d; done_lvl = lvl; rmode = rm; vmode = vm;
        ridx = 0; nstart = 0; nirq = 0; wr_acc = 0; hold_after = -1;
        valid_cfg = (n_in >= 1) && (n_in <= int'(MAX_WORDS)) && (n_out <= int'(MAX_WORDS));
        done_ok   = (d >= 1) && (d <= int'(TIMEOUT));
        if (!valid_cfg) begin
            exp_err = 1; exp_lat = 1;
        end else if (!done_ok) begin
            exp_err = 2; exp_lat = n_in + 1 + int'(TIMEOUT) + 1;
        end else begin
            exp_err = 0; exp_lat = n_in + 1 + d + n_out + 1;
        end
        if (valid_cfg)
            for (int i = 0; i < n_in; i++) q_wr.push_back({CNT_W'(i), mem[i]});
        if (valid_cfg && done_ok)
            for (int i = 0; i < n_out; i++) q_ob.push_back({CNT_W'(i), rwords[i]});
        q_end.push_back({4'h5, 4'(exp_err)});

        issue_start(n_in, n_out, t0);
        // A second start while the run is in flight must be ignored
        @(posedge clk);
        #1;
        cfg_n_in  = '0;
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;

        for (int k = 0; k < 400 && nirq == 0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("irq_once", 64'(nirq), 64'(1));
        check("done_status", 64'(status), 64'(5));
        check("done_error", 64'(error), 64'(exp_err));
        check("done_busy", 64'(busy), 64'(0));
        check("start_pulses", 64'(nstart), 64'(valid_cfg ? 1 : 0));
        check("wr_q_drained", 64'(q_wr.size()), 64'(0));
        check("ob_q_drained", 64'(q_ob.size()), 64'(0));
        check("end_q_drained", 64'(q_end.size()), 64'(0));
        if (rm == 0 && vm == 0 && nirq != 0)
            check("run_latency", 64'(irq_cyc - t0), 64'(exp_lat));
        q_wr.delete(); q_ob.delete(); q_end.delete();
        do_clear();
    endtask

    // Abort after two accepted words; nothing further may happen
    task automatic clear_mid_write();
        int t0;
        fresh_data();
        start_cyc = -1; done_d = 0; rmode = 0; vmode = 0;
        ridx = 0; nstart = 0; nirq = 0; wr_acc = 0; hold_after = 2;
        for (int i = 0; i < 2; i++) q_wr.push_back({CNT_W'(i), mem[i]});
        issue_start(6, 2, t0);
        for (int k = 0; k < 50 && wr_acc < 2; k++) begin
            @(posedge clk);
            #1;
        end
        check("clr_mid_words", 64'(wr_acc), 64'(2));
        do_clear();
        repeat (3) @(posedge clk);
        #1;
        check("clr_mid_irq", 64'(nirq), 64'(0));
        check("clr_mid_start", 64'(nstart), 64'(0));
        check("clr_mid_idle", 64'(status), 64'(0));
        check("clr_mid_q", 64'(q_wr.size()), 64'(0));
        q_wr.delete();
        hold_after = -1;
    endtask

    task automatic start_and_clear();
        nstart = 0; nirq = 0; wr_acc = 0;
        @(posedge clk);
        #1;
        cfg_n_in = CNT_W'(4); cfg_n_out = CNT_W'(2);
        cfg_start = 1'b1; cfg_clear = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0; cfg_clear = 1'b0;
        check("sc_status", 64'(status), 64'(0));
        check("sc_wr_valid", 64'(bus.acc_wr_valid_o), 64'(0));
        repeat (4) @(posedge clk);
        #1;
        check("sc_busy", 64'(busy), 64'(0));
        check("sc_irq", 64'(nirq), 64'(0));
        check("sc_words", 64'(wr_acc), 64'(0));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; cfg_clear = 1'b0;
        cfg_n_in = '0; cfg_n_out = '0;
        fresh_data();
        repeat (3) @(posedge clk);
        #1;
        check("rst_status", 64'(status), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_irq", 64'(irq), 64'(0));
        check("rst_wr_valid", 64'(bus.acc_wr_valid_o), 64'(0));
        check("rst_start", 64'(bus.acc_start_o), 64'(0));
        check("rst_rd_ready", 64'(bus.acc_rd_ready_o), 64'(0));
        check("rst_obuf_we", 64'(bus.obuf_we_o), 64'(0));
        check("rst_raddr", 64'(bus.ibuf_raddr_o), 64'(0));
        rst_n = 1'b1;

        run(4, 2, 5, 1'b0, 0, 0);
        run(4, 2, 3, 1'b0, 1, 0);
        run(0, 2, 3, 1'b0, 0, 0);
        run(17, 2, 3, 1'b0, 0, 0);
        run(3, 17, 3, 1'b0, 0, 0);
        run(3, 2, 0, 1'b0, 0, 0);
        run(2, 1, 16, 1'b0, 0, 0);
        run(2, 1, 17, 1'b0, 0, 0);
        clear_mid_write();
        run(4, 2, 2, 1'b0, 0, 0);
        start_and_clear();
        run(3, 0, 4, 1'b0, 0, 0);
        run(5, 3, 6, 1'b1, 0, 0);
        run(16, 16, 2, 1'b0, 0, 0);
        for (int it = 0; it < 25; it++) begin
            run($urandom_range(0, 18), $urandom_range(0, 17), $urandom_range(0, 20),
                1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
